// File: rtl/zeroheti_pkg.sv
// Core-level constants shared by zeroheti blocks.
package zeroheti_pkg;
  localparam int unsigned ArbMaxTrans = 2;
endpackage

// File: rtl/zeroheti_obi_arb_if.sv
// Bundle of the N-to-1 OBI arbiter's manager-side and subordinate-side signals.
interface zeroheti_obi_arb_if #(
  parameter int unsigned NumMgr    = 3,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
);
  localparam int unsigned BeWidth = DataWidth / 8;

  logic [NumMgr-1:0]                 mgr_req;
  logic [NumMgr-1:0][AddrWidth-1:0]  mgr_addr;
  logic [NumMgr-1:0]                 mgr_we;
  logic [NumMgr-1:0][BeWidth-1:0]    mgr_be;
  logic [NumMgr-1:0][DataWidth-1:0]  mgr_wdata;
  logic [NumMgr-1:0]                 mgr_gnt;
  logic [NumMgr-1:0]                 mgr_rvalid;
  logic [DataWidth-1:0]              mgr_rdata;
  logic                              mgr_err;
  logic                              sbr_req;
  logic [AddrWidth-1:0]              sbr_addr;
  logic                              sbr_we;
  logic [BeWidth-1:0]                sbr_be;
  logic [DataWidth-1:0]              sbr_wdata;
  logic                              sbr_gnt;
  logic                              sbr_rvalid;
  logic [DataWidth-1:0]              sbr_rdata;
  logic                              sbr_err;
  logic                              rsp_unexp;

  // Arbiter's view of the bundle.
  modport slave (
    input  mgr_req, mgr_addr, mgr_we, mgr_be, mgr_wdata,
    input  sbr_gnt, sbr_rvalid, sbr_rdata, sbr_err,
    output mgr_gnt, mgr_rvalid, mgr_rdata, mgr_err,
    output sbr_req, sbr_addr, sbr_we, sbr_be, sbr_wdata, rsp_unexp
  );

  // Surrounding managers and subordinate.
  modport master (
    output mgr_req, mgr_addr, mgr_we, mgr_be, mgr_wdata,
    output sbr_gnt, sbr_rvalid, sbr_rdata, sbr_err,
    input  mgr_gnt, mgr_rvalid, mgr_rdata, mgr_err,
    input  sbr_req, sbr_addr, sbr_we, sbr_be, sbr_wdata, rsp_unexp
  );
endinterface

// File: rtl/zeroheti_id_fifo.sv
// Show-ahead synchronous FIFO holding manager indices of outstanding transactions.
module zeroheti_id_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  typedef logic [PtrW-1:0] ptr_t;

  logic [Depth-1:0][Width-1:0] mem_q, mem_d;
  ptr_t                        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]             cnt_q, cnt_d;
  logic                        push_en, pop_en;

  function automatic ptr_t ptr_inc(ptr_t p);
    return (p == ptr_t'(Depth - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & ~empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_en) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop_en) rd_ptr_d = ptr_inc(rd_ptr_q);
    unique case ({push_en, pop_en})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: rtl/zeroheti_obi_arb.sv
// Round-robin N-to-1 OBI arbiter with request locking and in-order response routing.
module zeroheti_obi_arb
  import zeroheti_pkg::*;
#(
  parameter int unsigned NumMgr    = 3,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned MaxTrans  = ArbMaxTrans
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NumMgr-1:0]                  mgr_req_i,
  input  logic [NumMgr-1:0][AddrWidth-1:0]   mgr_addr_i,
  input  logic [NumMgr-1:0]                  mgr_we_i,
  input  logic [NumMgr-1:0][DataWidth/8-1:0] mgr_be_i,
  input  logic [NumMgr-1:0][DataWidth-1:0]   mgr_wdata_i,
  output logic [NumMgr-1:0]                  mgr_gnt_o,
  output logic [NumMgr-1:0]                  mgr_rvalid_o,
  output logic [DataWidth-1:0]               mgr_rdata_o,
  output logic                               mgr_err_o,
  output logic                               sbr_req_o,
  output logic [AddrWidth-1:0]               sbr_addr_o,
  output logic                               sbr_we_o,
  output logic [DataWidth/8-1:0]             sbr_be_o,
  output logic [DataWidth-1:0]               sbr_wdata_o,
  input  logic                               sbr_gnt_i,
  input  logic                               sbr_rvalid_i,
  input  logic [DataWidth-1:0]               sbr_rdata_i,
  input  logic                               sbr_err_i,
  output logic                               rsp_unexp_o
);
  localparam int unsigned IdxW = $clog2(NumMgr);
  typedef logic [IdxW-1:0] mgr_idx_t;
  typedef enum logic {IDLE, LOCKED} state_e;

  state_e   state_q, state_d;
  mgr_idx_t rr_q, rr_d, lock_q, lock_d;
  mgr_idx_t winner, sel, head;
  logic     any_req, fwd, push, pop, full, empty;

  function automatic mgr_idx_t idx_inc(mgr_idx_t i);
    return (i == mgr_idx_t'(NumMgr - 1)) ? '0 : i + mgr_idx_t'(1);
  endfunction

  // First requester at or after rr_q, wrapping around.
  always_comb begin
    int unsigned c;
    c       = 0;
    winner  = '0;
    any_req = 1'b0;
    for (int unsigned k = 0; k < NumMgr; k++) begin
      c = (32'(rr_q) + k) % NumMgr;
      if (!any_req && mgr_req_i[c]) begin
        any_req = 1'b1;
        winner  = mgr_idx_t'(c);
      end
    end
  end

  // Full comes from registered FIFO state, so rvalid never reaches sbr_req_o.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    lock_d  = lock_q;
    push    = 1'b0;
    sel     = (state_q == LOCKED) ? lock_q : winner;
    fwd     = ~full & ((state_q == LOCKED) ? mgr_req_i[lock_q] : any_req);
    unique case (state_q)
      IDLE: begin
        if (fwd) begin
          if (sbr_gnt_i) begin
            push = 1'b1;
            rr_d = idx_inc(winner);
          end else begin
            lock_d  = winner;
            state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        // A manager withdrawing its request is abandoned without a push.
        if (!mgr_req_i[lock_q]) begin
          state_d = IDLE;
        end else if (fwd && sbr_gnt_i) begin
          push    = 1'b1;
          rr_d    = idx_inc(lock_q);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sbr_req_o    = fwd;
    sbr_addr_o   = fwd ? mgr_addr_i[sel]  : '0;
    sbr_we_o     = fwd ? mgr_we_i[sel]    : 1'b0;
    sbr_be_o     = fwd ? mgr_be_i[sel]    : '0;
    sbr_wdata_o  = fwd ? mgr_wdata_i[sel] : '0;
    mgr_gnt_o    = '0;
    mgr_gnt_o[sel] = fwd & sbr_gnt_i;
    pop          = sbr_rvalid_i & ~empty;
    mgr_rvalid_o = '0;
    mgr_rvalid_o[head] = pop;
    rsp_unexp_o  = sbr_rvalid_i & empty;
  end

  assign mgr_rdata_o = sbr_rdata_i;
  assign mgr_err_o   = sbr_err_i;

  zeroheti_id_fifo #(
    .Depth (MaxTrans),
    .Width (IdxW)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (sel),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rr_q    <= '0;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      lock_q  <= lock_d;
    end
  end
endmodule

// File: tb/tb_zeroheti_obi_arb.sv
// Directed bench for zeroheti_obi_arb: 3 managers, two outstanding transactions.
module tb_zeroheti_obi_arb;
  localparam int unsigned NM = 3;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MT = 2;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  zeroheti_obi_arb_if #(.NumMgr(NM), .AddrWidth(AW), .DataWidth(DW)) bus ();

  zeroheti_obi_arb #(
    .NumMgr(NM), .AddrWidth(AW), .DataWidth(DW), .MaxTrans(MT)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .mgr_req_i    (bus.mgr_req),
    .mgr_addr_i   (bus.mgr_addr),
    .mgr_we_i     (bus.mgr_we),
    .mgr_be_i     (bus.mgr_be),
    .mgr_wdata_i  (bus.mgr_wdata),
    .mgr_gnt_o    (bus.mgr_gnt),
    .mgr_rvalid_o (bus.mgr_rvalid),
    .mgr_rdata_o  (bus.mgr_rdata),
    .mgr_err_o    (bus.mgr_err),
    .sbr_req_o    (bus.sbr_req),
    .sbr_addr_o   (bus.sbr_addr),
    .sbr_we_o     (bus.sbr_we),
    .sbr_be_o     (bus.sbr_be),
    .sbr_wdata_o  (bus.sbr_wdata),
    .sbr_gnt_i    (bus.sbr_gnt),
    .sbr_rvalid_i (bus.sbr_rvalid),
    .sbr_rdata_i  (bus.sbr_rdata),
    .sbr_err_i    (bus.sbr_err),
    .rsp_unexp_o  (bus.rsp_unexp)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] atab [3] = '{32'h0000_0100, 32'h0000_0200, 32'h0000_0300};
  logic [2:0]  oh   [3] = '{3'b001, 3'b010, 3'b100};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [NM-1:0] req, input logic gnt, input logic rv);
    bus.mgr_req    = req;
    bus.sbr_gnt    = gnt;
    bus.sbr_rvalid = rv;
    #1;
  endtask

  initial begin
    for (int i = 0; i < NM; i++) begin
      bus.mgr_addr[i]  = 32'h100 * (i + 1);
      bus.mgr_we[i]    = i[0];
      bus.mgr_be[i]    = 4'hF;
      bus.mgr_wdata[i] = 32'hA000_0000 + i;
    end
    bus.sbr_rdata = 32'hDEAD_BEEF;
    bus.sbr_err   = 1'b0;
    drive('0, 1'b0, 1'b0);
    #12;
    chk("rst_sbr_req",   bus.sbr_req,    0);
    chk("rst_sbr_addr",  bus.sbr_addr,   0);
    chk("rst_gnt",       bus.mgr_gnt,    0);
    chk("rst_rvalid",    bus.mgr_rvalid, 0);
    chk("rst_unexp",     bus.rsp_unexp,  0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();

    // Unexpected response with empty FIFO; also response pass-through.
    bus.sbr_err = 1'b1;
    drive('0, 1'b0, 1'b1);
    chk("unexp_pulse",  bus.rsp_unexp,  1);
    chk("unexp_rvalid", bus.mgr_rvalid, 0);
    chk("rdata_pass",   bus.mgr_rdata,  32'hDEAD_BEEF);
    chk("err_pass",     bus.mgr_err,    1);
    tick();
    bus.sbr_err = 1'b0;
    drive('0, 1'b0, 1'b0);
    chk("unexp_end", bus.rsp_unexp, 0);
    tick();

    // Round robin, all requesting, 1-cycle response (push and pop coincide).
    for (int k = 0; k < 6; k++) begin
      drive(3'b111, 1'b1, k > 0);
      chk("rr_gnt",  bus.mgr_gnt,  oh[k % 3]);
      chk("rr_addr", bus.sbr_addr, atab[k % 3]);
      if (k > 0) chk("rr_rvalid", bus.mgr_rvalid, oh[(k - 1) % 3]);
      tick();
    end
    drive('0, 1'b0, 1'b1);
    chk("rr_last_rvalid", bus.mgr_rvalid, 3'b100);
    tick();
    drive('0, 1'b0, 1'b1);
    chk("rr_drained_unexp", bus.rsp_unexp,  1);
    chk("rr_drained_rv",    bus.mgr_rvalid, 0);
    tick();

    // Request lock: mgr1 held, mgr0 joins while locked.
    drive(3'b010, 1'b0, 1'b0);
    chk("lock_req",  bus.sbr_req,  1);
    chk("lock_addr0", bus.sbr_addr, 32'h200);
    chk("lock_nognt", bus.mgr_gnt, 0);
    tick();
    drive(3'b011, 1'b0, 1'b0);
    chk("lock_addr1", bus.sbr_addr, 32'h200);
    tick();
    drive(3'b011, 1'b0, 1'b0);
    chk("lock_addr2", bus.sbr_addr, 32'h200);
    tick();
    drive(3'b011, 1'b1, 1'b0);
    chk("lock_gnt", bus.mgr_gnt, 3'b010);
    tick();
    drive(3'b011, 1'b1, 1'b0);
    chk("lock_next_gnt",  bus.mgr_gnt,  3'b001);
    chk("lock_next_addr", bus.sbr_addr, 32'h100);
    tick();
    drive('0, 1'b0, 1'b1);
    chk("lock_rv1", bus.mgr_rvalid, 3'b010);
    tick();
    drive('0, 1'b0, 1'b1);
    chk("lock_rv0", bus.mgr_rvalid, 3'b001);
    tick();

    // FIFO full: two grants, responses held back.
    drive(3'b111, 1'b1, 1'b0);
    chk("full_g1", bus.mgr_gnt, 3'b010);
    tick();
    drive(3'b111, 1'b1, 1'b0);
    chk("full_g2", bus.mgr_gnt, 3'b100);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(3'b111, 1'b1, 1'b0);
      chk("full_noreq", bus.sbr_req, 0);
      chk("full_nognt", bus.mgr_gnt, 0);
      tick();
    end
    drive(3'b111, 1'b1, 1'b1);
    chk("full_pop_noreq", bus.sbr_req,    0);
    chk("full_pop_nognt", bus.mgr_gnt,    0);
    chk("full_pop_rv",    bus.mgr_rvalid, 3'b010);
    tick();
    drive(3'b111, 1'b1, 1'b0);
    chk("full_g3_req",  bus.sbr_req,  1);
    chk("full_g3_gnt",  bus.mgr_gnt,  3'b001);
    chk("full_g3_addr", bus.sbr_addr, 32'h100);
    tick();
    drive('0, 1'b0, 1'b1);
    chk("full_rv2", bus.mgr_rvalid, 3'b100);
    tick();
    drive('0, 1'b0, 1'b1);
    chk("full_rv0", bus.mgr_rvalid, 3'b001);
    tick();

    // Locked requester withdraws: abandoned, nothing recorded.
    drive(3'b100, 1'b0, 1'b0);
    chk("drop_req", bus.sbr_req, 1);
    tick();
    drive('0, 1'b0, 1'b0);
    chk("drop_noreq", bus.sbr_req, 0);
    tick();
    drive('0, 1'b0, 1'b1);
    chk("drop_nopush", bus.rsp_unexp, 1);
    tick();
    drive(3'b111, 1'b1, 1'b0);
    chk("drop_rr_kept", bus.mgr_gnt, 3'b010);
    tick();
    drive('0, 1'b0, 1'b1);
    chk("drop_rv", bus.mgr_rvalid, 3'b010);
    tick();

    // Reset while LOCKED with one transaction outstanding.
    drive(3'b001, 1'b1, 1'b0);
    chk("mid_g", bus.mgr_gnt, 3'b001);
    tick();
    drive(3'b100, 1'b0, 1'b0);
    tick();
    drive(3'b111, 1'b0, 1'b0);
    chk("mid_locked_addr", bus.sbr_addr, 32'h300);
    drive('0, 1'b0, 1'b0);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_req",  bus.sbr_req,    0);
    chk("mid_rst_gnt",  bus.mgr_gnt,    0);
    chk("mid_rst_rv",   bus.mgr_rvalid, 0);
    chk("mid_rst_addr", bus.sbr_addr,   0);
    tick();
    rst_ni = 1'b1;
    tick();
    drive('0, 1'b0, 1'b1);
    chk("post_rst_empty", bus.rsp_unexp,  1);
    chk("post_rst_rv",    bus.mgr_rvalid, 0);
    tick();
    drive(3'b111, 1'b1, 1'b0);
    chk("post_rst_rr0", bus.mgr_gnt, 3'b001);
    tick();
    drive('0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
